// File: rtl/tdm_chan_mux.sv
// tdm_chan_mux: registered N:1 channel multiplexer with a valid/ready output
// stream. Manual mode loads the selected channel. Auto mode scans the enabled
// channels in round-robin order, starting from a scan pointer. Each output
// word carries the index of the channel it came from.
module tdm_chan_mux #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] din,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W + 1)'(NUM_CH);

    logic [DATA_W-1:0] out_data_reg;
    logic [SEL_W-1:0]  out_ch_reg;
    logic              out_valid_reg;
    logic              sel_err_reg;
    logic [SEL_W-1:0]  ptr_reg;
    logic [SEL_W-1:0]  ptr_next;

    logic [DATA_W-1:0] ch_word [NUM_CH];
    logic [NUM_CH-1:0] sel_hit;
    logic              sel_ok;
    logic              can_load;
    logic              load_go;
    logic [SEL_W-1:0]  load_ch;
    logic              scan_found;
    logic [SEL_W-1:0]  scan_ch;
    logic [SEL_W:0]    cand;

    // Unpack the channel words and decode the manual select against the mask.
    // A select beyond the last channel matches no entry, so it can never
    // address a channel that does not exist.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_word[gi] = din[gi*DATA_W +: DATA_W];
            assign sel_hit[gi] = (sel == SEL_W'(gi)) && ch_mask[gi];
        end
    endgenerate

    assign sel_ok = |sel_hit;

    // Round-robin search: walk the offsets from the far end back to zero so
    // that the last hit written is the first eligible channel at or after ptr.
    always_comb begin
        scan_found = 1'b0;
        scan_ch    = ptr_reg;
        cand       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_reg} + (SEL_W + 1)'(i);
            if (cand >= NUM_CH_X) begin
                cand = cand - NUM_CH_X;
            end
            if (ch_mask[cand[SEL_W-1:0]]) begin
                scan_found = 1'b1;
                scan_ch    = cand[SEL_W-1:0];
            end
        end
    end

    // A new word may enter only when the output register is empty or its
    // word is being taken in this same cycle.
    assign can_load = en && (!out_valid_reg || out_ready);
    assign load_go  = can_load && (mode ? scan_found : sel_ok);
    assign load_ch  = mode ? scan_ch : sel;
    assign ptr_next = (scan_ch == LAST_CH) ? '0 : scan_ch + SEL_W'(1);

    // Output register, scan pointer and select-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            sel_err_reg   <= 1'b0;
            ptr_reg       <= '0;
        end else begin
            sel_err_reg <= can_load && !mode && !sel_ok;
            if (load_go) begin
                out_data_reg  <= ch_word[load_ch];
                out_ch_reg    <= load_ch;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (can_load && mode && scan_found) begin
                ptr_reg <= ptr_next;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;
    assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_tdm_chan_mux.sv
// Testbench for tdm_chan_mux: table-driven vectors, hand-written corner
// sequences and a randomized run checked against a behavioural model.
module tb_tdm_chan_mux;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     en = 1'b0;
    logic                     mode = 1'b0;
    logic [SEL_W-1:0]         sel = '0;
    logic [NUM_CH-1:0]        ch_mask = 8'hFF;
    logic [NUM_CH*DATA_W-1:0] din = '0;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic                     sel_err;

    tdm_chan_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .ch_mask(ch_mask), .din(din), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Behavioural model state: the word held at the output plus the scan pointer.
    bit       m_valid = 0;
    bit [7:0] m_data  = 0;
    bit [2:0] m_ch    = 0;
    int       m_ptr   = 0;
    bit       m_err   = 0;

    typedef struct {
        bit       en;
        bit       mode;
        bit [2:0] sel;
        bit [7:0] mask;
        bit       ready;
        bit       ev;
        bit [7:0] ed;
        bit [2:0] ech;
        bit       eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit e, bit md, bit [2:0] s, bit [7:0] mk_mask, bit r,
                                bit ev, bit [7:0] ed, bit [2:0] ech, bit eerr);
        vec_t v;
        v.en = e; v.mode = md; v.sel = s; v.mask = mk_mask; v.ready = r;
        v.ev = ev; v.ed = ed; v.ech = ech; v.eerr = eerr;
        return v;
    endfunction

    // Applies the rules directly: decide what the next edge does from the
    // current inputs and the word currently held.
    task automatic model_step();
        bit can_load;
        bit loaded;
        int k;
        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_err = 0;
            return;
        end
        can_load = en && (!m_valid || out_ready);
        loaded   = 0;
        m_err    = 0;
        if (can_load) begin
            if (!mode) begin
                if (int'(sel) < NUM_CH && ch_mask[sel]) begin
                    m_data = din[int'(sel)*8 +: 8];
                    m_ch   = sel;
                    loaded = 1;
                end else begin
                    m_err = 1;
                end
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    k = (m_ptr + i) % NUM_CH;
                    if (!loaded && ch_mask[k]) begin
                        m_data = din[k*8 +: 8];
                        m_ch   = 3'(k);
                        m_ptr  = (k + 1) % NUM_CH;
                        loaded = 1;
                    end
                end
            end
        end
        if (loaded) m_valid = 1;
        else if (m_valid && out_ready) m_valid = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d rst=%0b en=%0b mode=%0b sel=%0d mask=%02h rdy=%0b -> valid=%0b ch=%0d data=%02h err=%0b",
                 cyc, rst, en, mode, sel, ch_mask, out_ready, out_valid, out_ch, out_data, sel_err);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk_out(string tag, bit ev, bit [7:0] ed, bit [2:0] ech, bit eerr);
        chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, "_err"}, 32'(sel_err), 32'(eerr));
        if (ev) begin
            chk({tag, "_data"}, 32'(out_data), 32'(ed));
            chk({tag, "_ch"}, 32'(out_ch), 32'(ech));
        end
    endtask

    task automatic din_default();
        for (int k = 0; k < NUM_CH; k++) din[k*8 +: 8] = 8'(8'h10 + k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bit [2:0] auto_seq [8];
        int r;
        auto_seq = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd2, 3'd5, 3'd7};
        din_default();

        // Power-up reset.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_out("rst0", 0, 0, 0, 0);
        chk("rst0_data", 32'(out_data), 32'h0);
        chk("rst0_ch", 32'(out_ch), 32'h0);

        // Reset while a word is pending, then first auto load picks ch0.
        en = 1; mode = 1; ch_mask = 8'hFF; out_ready = 0;
        tick();
        chk_out("pend", 1, 8'h10, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst1_valid", 32'(out_valid), 32'h0);
        chk("rst1_data", 32'(out_data), 32'h0);
        chk("rst1_ch", 32'(out_ch), 32'h0);
        tick();
        chk_out("first_auto", 1, 8'h10, 0, 0);

        // Table: manual stepping, invalid select, auto scan, empty mask.
        for (int s = 0; s < 8; s++)
            vecs.push_back(mk(1, 0, 3'(s), 8'hFF, 1, 1, 8'(8'h10 + s), 3'(s), 0));
        vecs.push_back(mk(1, 0, 3'd2, 8'hFB, 1, 0, 8'h00, 3'd0, 1));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 1, 3'd0, 8'hA5, 1, 1, 8'(8'h10 + auto_seq[i]), auto_seq[i], 0));
        vecs.push_back(mk(1, 1, 3'd0, 8'h00, 1, 0, 8'h00, 3'd0, 0));
        vecs.push_back(mk(1, 1, 3'd0, 8'h00, 1, 0, 8'h00, 3'd0, 0));

        do_reset();
        foreach (vecs[i]) begin
            en = vecs[i].en; mode = vecs[i].mode; sel = vecs[i].sel;
            ch_mask = vecs[i].mask; out_ready = vecs[i].ready;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ech, vecs[i].eerr);
        end

        // Backpressure: ch0 held for 5 cycles, then ch1 and ch2 follow.
        do_reset();
        en = 1; mode = 1; ch_mask = 8'hFF; out_ready = 0;
        tick();
        chk_out("bp_first", 1, 8'h10, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("bp_hold", 1, 8'h10, 0, 0);
        end
        out_ready = 1;
        tick();
        chk_out("bp_rel1", 1, 8'h11, 1, 0);
        tick();
        chk_out("bp_rel2", 1, 8'h12, 2, 0);

        // en=0 with a pending word: held until taken, then empty.
        out_ready = 0;
        tick();
        chk_out("en_hold0", 1, 8'h12, 2, 0);
        en = 0;
        tick();
        tick();
        chk_out("en_hold1", 1, 8'h12, 2, 0);
        out_ready = 1;
        tick();
        chk_out("en_drain", 0, 0, 0, 0);

        // Mode switch keeps the scan pointer; mid-stream reset clears it.
        do_reset();
        en = 1; out_ready = 1; mode = 1; ch_mask = 8'h10;
        tick();
        chk_out("ms_ptr5", 1, 8'h14, 4, 0);
        ch_mask = 8'hFF; mode = 0; sel = 3'd3;
        tick();
        chk_out("ms_manual", 1, 8'h13, 3, 0);
        mode = 1;
        tick();
        chk_out("ms_auto5", 1, 8'h15, 5, 0);
        tick();
        chk_out("ms_auto6", 1, 8'h16, 6, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        tick();
        chk_out("mid_rst_ptr0", 1, 8'h10, 0, 0);

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 31) == 0);
            en   = ($urandom_range(0, 7) != 0);
            mode = 1'($urandom_range(0, 1));
            sel  = 3'($urandom);
            r    = $urandom_range(0, 3);
            ch_mask   = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            din = {$urandom, $urandom};
            tick();
            chk_out("rand", m_valid, m_data, m_ch, m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
